// File: rtl/tmr_alu_sequencer.sv
// tmr_alu_sequencer: serializes one ALU request as a frame onto the loader,
// waits for the replicas to settle, votes/classifies the triple results,
// retries uncorrectable compares and returns the outcome over valid/ready.
module tmr_alu_sequencer #(
  parameter int FRAME_W   = 35,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic             ser_data,
  output logic             ser_ready,
  input  logic [15:0]      alu1_res,
  input  logic [15:0]      alu2_res,
  input  logic [15:0]      alu3_res,
  input  logic [14:0]      alu1_mul,
  input  logic [14:0]      alu2_mul,
  input  logic [14:0]      alu3_mul,
  input  logic [15:0]      voted_res,
  input  logic [14:0]      voted_mul,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_out,
  output logic [14:0]      res_mul,
  output logic [1:0]       res_fault,
  output logic [2:0]       res_bad_lane,
  output logic [CNT_W-1:0] fault_cnt,
  input  logic             clr_cnt
);

  // One counter walks both the frame bit index and the settle wait.
  localparam int CYC_W = $clog2(FRAME_W + SETTLE + 1);
  localparam int RT_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]         r_state;
  logic [FRAME_W-1:0] r_frame;
  logic [CYC_W-1:0]   r_cyc;
  logic [RT_W-1:0]    r_retry;
  logic [30:0]        r_res;
  logic [1:0]         r_fault;
  logic [2:0]         r_bad;
  logic [CNT_W-1:0]   r_cnt;

  logic [30:0] w_w1, w_w2, w_w3, w_wv, w_out;
  logic        w_e12, w_e13, w_e23;
  logic [1:0]  w_fault;
  logic [2:0]  w_bad;
  logic        w_retry;
  logic        w_done;

  assign w_w1 = {alu1_mul, alu1_res};
  assign w_w2 = {alu2_mul, alu2_res};
  assign w_w3 = {alu3_mul, alu3_res};
  assign w_wv = {voted_mul, voted_res};

  assign w_e12 = (w_w1 == w_w2);
  assign w_e13 = (w_w1 == w_w3);
  assign w_e23 = (w_w2 == w_w3);

  // Classify the sampled lane words; only meaningful during CHECK.
  always_comb begin
    w_out   = w_wv;
    w_fault = 2'b00;
    w_bad   = 3'b000;
    w_retry = 1'b0;
    if (w_e12 && w_e13) begin
      w_out   = w_w1;
      w_fault = (w_wv == w_w1) ? 2'b00 : 2'b11;
    end else if (w_e12 || w_e13 || w_e23) begin
      // Majority word and the one-hot position of the odd lane.
      if (w_e12) begin
        w_out = w_w1;
        w_bad = 3'b100;
      end else if (w_e13) begin
        w_out = w_w1;
        w_bad = 3'b010;
      end else begin
        w_out = w_w2;
        w_bad = 3'b001;
      end
      if (w_wv == w_out) begin
        w_fault = 2'b01;
      end else begin
        w_fault = 2'b11;
        w_bad   = 3'b000;
      end
    end else if (r_retry < RT_W'(MAX_RETRY)) begin
      w_retry = 1'b1;
    end else begin
      w_out   = w_wv;
      w_fault = 2'b10;
      w_bad   = 3'b111;
    end
  end

  // Entering RESP from CHECK with a final verdict.
  assign w_done = (r_state == S_CHECK) && !w_retry;

  assign req_ready    = (r_state == S_IDLE);
  assign res_valid    = (r_state == S_RESP);
  assign ser_ready    = (r_state == S_SHIFT);
  assign ser_data     = (r_state == S_SHIFT) ? r_frame[r_cyc] : 1'b0;
  assign res_out      = r_res[15:0];
  assign res_mul      = r_res[30:16];
  assign res_fault    = r_fault;
  assign res_bad_lane = r_bad;
  assign fault_cnt    = r_cnt;

  // Sequencer FSM: latch, shift, settle, check/retry, hold response.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_cyc   <= '0;
      r_retry <= '0;
      r_res   <= '0;
      r_fault <= 2'b00;
      r_bad   <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_frame <= {req_op, req_b, req_a};
            r_retry <= '0;
            r_cyc   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cyc == CYC_W'(FRAME_W - 1)) begin
            r_cyc   <= '0;
            r_state <= S_SETTLE;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cyc == CYC_W'(SETTLE - 1)) begin
            r_cyc   <= '0;
            r_state <= S_CHECK;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_retry) begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_res   <= w_out;
            r_fault <= w_fault;
            r_bad   <= w_bad;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of non-clean results; clear wins over an increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_done && (w_fault != 2'b00) && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
